uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmitter: the transmit-side counterpart of the team's UART receiver, driving the same 8N1 line format.
- Accepts words from the AXI-Lite register front-end into a small internal FIFO and serialises them LSB-first on txd.
- Each bit lasts `prescale` clock cycles, the same bit period the receiver samples with.
- Sits between the AXI-Lite TX data register and the pad.

Parameters:
DATA_WIDTH, 8, data bits per frame (1..15)
FIFO_DEPTH, 4, TX FIFO entries; power of two, >=2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
tx_data  input  DATA_WIDTH  word to transmit
tx_valid  input  1  write strobe; word accepted when tx_valid && tx_ready at a clk edge
tx_ready  output  1  FIFO not full (registered state, not combinational on tx_valid)
prescale  input  16  clocks per bit; sampled only at frame start
txd  output  1  serial line, idle high, registered
busy  output  1  high whenever the FSM is not IDLE
tx_empty  output  1  FIFO empty and FSM IDLE (line fully drained)
overrun_error  output  1  sticky; set when tx_valid is asserted while tx_ready=0

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-safe deassert):
  - txd=1, busy=0, tx_ready=1, tx_empty=1, overrun_error=0.
  - FSM=IDLE; FIFO pointers and count cleared.
  - Reset mid-frame aborts the frame immediately; txd returns high without waiting for a clock.
- FIFO:
  - Circular buffer with read/write pointers and a count of width clog2(FIFO_DEPTH)+1.
  - Write on tx_valid && tx_ready.
  - Pop only by the FSM, and only when count!=0.
  - Write and pop in the same cycle: count unchanged.
  - Write attempted while full: data dropped, overrun_error<=1, held until reset. A pop in the same cycle does not make the write succeed.
  - tx_ready = (count != FIFO_DEPTH).
- Bit period: eff_ps = latched prescale, with 0 treated as 1. Every bit (start, data, stop) is held for exactly eff_ps cycles.
- FSM states: IDLE, START, DATA, STOP. A down-counter timer (16 b) and bit_cnt (4 b) track progress.
- IDLE:
  - If count!=0: pop head into shifter, latch prescale, txd<=0, timer<=eff_ps-1, bit_cnt<=0, go to START.
  - Else txd<=1.
- START: when timer==0, txd<=shifter[0], shift right, timer<=eff_ps-1, go to DATA. Otherwise decrement timer.
- DATA:
  - When timer==0 and bit_cnt!=DATA_WIDTH-1: txd<=shifter[0], shift, bit_cnt++, reload timer.
  - When timer==0 and bit_cnt==DATA_WIDTH-1: txd<=1, reload timer, go to STOP.
- STOP: when timer==0, perform the IDLE check in the same cycle.
  - FIFO non-empty: pop, txd<=0, go to START. Back-to-back frames have no idle gap.
  - Else go to IDLE.
- Latency: word written at edge N, line idle and FIFO empty → txd falls after edge N+1.
- Frame length is exactly (DATA_WIDTH+2)*eff_ps cycles.
- Changes to prescale mid-frame have no effect until the next frame start.
- busy is combinational from state. tx_empty = (count==0) && (state==IDLE).

Test Plan:
1. Reset, prescale=4, write 0xA5 once → txd low one cycle after the write edge. Then txd = 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles (40 cycles total). busy high for 40 cycles; tx_empty rises after the stop bit.
2. prescale=2, write 0x00,0xFF,0x55,0x81 on consecutive cycles → all accepted, tx_ready stays 1. Four frames back-to-back with no idle cycle between stop and next start; a receiver loopback at prescale=2 returns the same four bytes in order.
3. prescale=8, write 6 words while the first frame is active → tx_ready drops after the 5th write (one in shifter, 4 queued). The 6th write is dropped and overrun_error=1. Exactly 5 frames are transmitted.
4. prescale=0 and prescale=1, write 0x3C → both give 1 cycle per bit: txd=0,0,0,1,1,1,1,0,0,1.
5. prescale=16, write 0xC3; change prescale to 4 during bit 3 → remaining bits stay 16 cycles. A following frame uses 4.
6. Assert rst_n low mid-data-bit with 2 words queued → txd=1 with no clock edge needed, busy=0, tx_empty=1, overrun_error=0. No further frames after release.

Source files
------------

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//
// 8N1-style UART transmitter. Words written through the tx_valid/tx_ready
// handshake are queued in a small circular FIFO and serialised LSB-first on
// txd: one start bit (0), DATA_WIDTH data bits, one stop bit (1). Every bit
// is held for eff_ps clocks, where eff_ps is the prescale value latched when
// the frame starts (0 is treated as 1).
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   rst_n          asynchronous active-low reset
//   tx_data        word to transmit
//   tx_valid       write strobe; accepted when tx_valid && tx_ready
//   tx_ready       FIFO not full (from registered count only)
//   prescale       clocks per bit, sampled only at frame start
//   txd            serial line, idle high, registered
//   busy           high whenever the FSM is not IDLE
//   tx_empty       FIFO empty and FSM IDLE (line fully drained)
//   overrun_error  sticky; set by a write attempt while the FIFO is full
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [15:0]           prescale,
    output logic                  txd,
    output logic                  busy,
    output logic                  tx_empty,
    output logic                  overrun_error
);

    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]       LAST_BIT = 4'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic                  overrun_reg;
    logic                  fifo_full;
    logic                  fifo_nempty;
    logic                  wr_en;
    logic                  pop;

    assign fifo_full   = (count_reg == FULL_CNT);
    assign fifo_nempty = (count_reg != '0);
    // Readiness comes from the registered count only, so a pop in the same
    // cycle never lets a write into a full FIFO.
    assign wr_en       = tx_valid && !fifo_full;

    // Storage carries no reset so it can map onto RAM resources.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (wr_en && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (!wr_en && pop) begin
                count_reg <= count_reg - CNT_W'(1);
            end
            if (tx_valid && fifo_full) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    state_t                state_reg,   state_next;
    logic [DATA_WIDTH-1:0] shifter_reg, shifter_next;
    logic [15:0]           timer_reg,   timer_next;
    logic [15:0]           eff_ps_reg,  eff_ps_next;
    logic [3:0]            bit_cnt_reg, bit_cnt_next;
    logic                  txd_reg,     txd_next;
    logic [15:0]           start_ps;
    logic                  timer_done;
    logic                  start_frame;

    // A zero prescale would otherwise mean a 65536-cycle bit.
    assign start_ps   = (prescale == 16'd0) ? 16'd1 : prescale;
    assign timer_done = (timer_reg == 16'd0);

    // State register (the line register resets high asynchronously so an
    // aborted frame releases the pad without waiting for a clock).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            shifter_reg <= '0;
            timer_reg   <= '0;
            eff_ps_reg  <= 16'd1;
            bit_cnt_reg <= '0;
            txd_reg     <= 1'b1;
        end else begin
            state_reg   <= state_next;
            shifter_reg <= shifter_next;
            timer_reg   <= timer_next;
            eff_ps_reg  <= eff_ps_next;
            bit_cnt_reg <= bit_cnt_next;
            txd_reg     <= txd_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next   = state_reg;
        shifter_next = shifter_reg;
        timer_next   = timer_reg;
        eff_ps_next  = eff_ps_reg;
        bit_cnt_next = bit_cnt_reg;
        txd_next     = txd_reg;
        start_frame  = 1'b0;
        pop          = 1'b0;

        case (state_reg)
            IDLE: begin
                txd_next = 1'b1;
                if (fifo_nempty) begin
                    start_frame = 1'b1;
                end
            end

            START: begin
                if (timer_done) begin
                    txd_next     = shifter_reg[0];
                    shifter_next = shifter_reg >> 1;
                    timer_next   = eff_ps_reg - 16'd1;
                    state_next   = DATA;
                end else begin
                    timer_next = timer_reg - 16'd1;
                end
            end

            DATA: begin
                if (timer_done) begin
                    timer_next = eff_ps_reg - 16'd1;
                    if (bit_cnt_reg != LAST_BIT) begin
                        txd_next     = shifter_reg[0];
                        shifter_next = shifter_reg >> 1;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else begin
                        txd_next   = 1'b1;
                        state_next = STOP;
                    end
                end else begin
                    timer_next = timer_reg - 16'd1;
                end
            end

            STOP: begin
                if (timer_done) begin
                    // Chain straight into the next start bit when more data
                    // is queued, so back-to-back frames carry no idle gap.
                    if (fifo_nempty) begin
                        start_frame = 1'b1;
                    end else begin
                        txd_next   = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer_reg - 16'd1;
                end
            end

            default: begin
                txd_next   = 1'b1;
                state_next = IDLE;
            end
        endcase

        // Frame start: pop the head word and latch this frame's bit period.
        if (start_frame) begin
            pop          = 1'b1;
            shifter_next = mem[rd_ptr_reg];
            eff_ps_next  = start_ps;
            timer_next   = start_ps - 16'd1;
            bit_cnt_next = 4'd0;
            txd_next     = 1'b0;
            state_next   = START;
        end
    end

    // Output logic
    always_comb begin
        busy     = (state_reg != IDLE);
        tx_empty = !fifo_nempty && (state_reg == IDLE);
    end

    assign tx_ready      = !fifo_full;
    assign txd           = txd_reg;
    assign overrun_error = overrun_reg;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
//
// Directed self-checking bench for uart_tx (DATA_WIDTH=8, FIFO_DEPTH=4).
// Inputs are driven and outputs sampled on the falling clock edge. A small
// behavioural receiver decodes txd back into bytes for the loopback tests.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    logic        clk;
    logic        rst_n;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] prescale;
    logic        txd;
    logic        busy;
    logic        tx_empty;
    logic        overrun_error;

    int checks = 0;
    int passed = 0;

    logic [255:0] tv;
    logic [255:0] bv;
    logic [255:0] exp_tv;
    logic [255:0] exp_bv;

    // Receiver model: {stop_bit, data}
    logic       rx_en = 1'b0;
    int         rx_ps = 2;
    logic [8:0] rx_q[$];

    uart_tx #(
        .DATA_WIDTH(8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .prescale     (prescale),
        .txd          (txd),
        .busy         (busy),
        .tx_empty     (tx_empty),
        .overrun_error(overrun_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mid-bit sampling receiver, started by the first low sample of txd.
    initial begin : rx_model
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (rx_en && txd === 1'b0) begin
                repeat (rx_ps / 2) @(negedge clk);
                for (int b = 0; b < 8; b++) begin
                    repeat (rx_ps) @(negedge clk);
                    d[b] = txd;
                end
                repeat (rx_ps) @(negedge clk);
                rx_q.push_back({txd, d});
            end
        end
    end

    // 8N1 frame, index 0 is the first bit on the line.
    function automatic logic [9:0] frame(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    // Stretch each of nbits line bits to ps samples.
    function automatic logic [255:0] expand(input logic [63:0] bits, input int nbits, input int ps);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < nbits * ps; i++) v[i] = bits[i / ps];
        return v;
    endfunction

    function automatic logic [255:0] ones(input int n);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic write_word(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic capture(input int n);
        tv = '0;
        bv = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tv[i] = txd;
            bv[i] = busy;
        end
    endtask

    task automatic test_reset;
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        prescale = 16'd4;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (txd !== 1'b1) $display("FAIL reset_async_txd: got %b expected 1", txd); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_async_busy: got %b expected 0", busy); else passed++;
        checks++; if (tx_ready !== 1'b1) $display("FAIL reset_async_ready: got %b expected 1", tx_ready); else passed++;
        checks++; if (tx_empty !== 1'b1) $display("FAIL reset_async_empty: got %b expected 1", tx_empty); else passed++;
        checks++; if (overrun_error !== 1'b0) $display("FAIL reset_async_overrun: got %b expected 0", overrun_error); else passed++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (txd !== 1'b1) $display("FAIL reset_idle_txd: got %b expected 1", txd); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy); else passed++;
        checks++; if (tx_ready !== 1'b1) $display("FAIL reset_idle_ready: got %b expected 1", tx_ready); else passed++;
        checks++; if (tx_empty !== 1'b1) $display("FAIL reset_idle_empty: got %b expected 1", tx_empty); else passed++;
        checks++; if (overrun_error !== 1'b0) $display("FAIL reset_idle_overrun: got %b expected 0", overrun_error); else passed++;
        $display("test_reset done: %0d/%0d", passed, checks);
    endtask

    // 0xA5 at prescale 4: line 0,1,0,1,0,0,1,0,1,1, four cycles each.
    task automatic test_single_frame;
        prescale = 16'd4;
        write_word(8'hA5);
        checks++; if (txd !== 1'b1) $display("FAIL t1_still_idle_at_write: got %b expected 1", txd); else passed++;
        checks++; if (tx_empty !== 1'b0) $display("FAIL t1_empty_after_write: got %b expected 0", tx_empty); else passed++;
        capture(40);
        exp_tv = expand(64'(frame(8'hA5)), 10, 4);
        exp_bv = ones(40);
        checks++; if (tv !== exp_tv) $display("FAIL t1_waveform: got %h expected %h", tv, exp_tv); else passed++;
        checks++; if (bv !== exp_bv) $display("FAIL t1_busy: got %h expected %h", bv, exp_bv); else passed++;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL t1_busy_after: got %b expected 0", busy); else passed++;
        checks++; if (tx_empty !== 1'b1) $display("FAIL t1_empty_after: got %b expected 1", tx_empty); else passed++;
        checks++; if (txd !== 1'b1) $display("FAIL t1_txd_after: got %b expected 1", txd); else passed++;
        $display("test_single_frame done: %0d/%0d", passed, checks);
    endtask

    task automatic test_back_to_back;
        logic [7:0] words [4];
        int         ready_bad;
        logic [35:0] got;
        words = '{8'h00, 8'hFF, 8'h55, 8'h81};
        ready_bad = 0;
        prescale  = 16'd2;
        rx_ps     = 2;
        rx_q.delete();
        rx_en     = 1'b1;
        tv = '0;
        bv = '0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tx_data  = words[i];
            tx_valid = 1'b1;
            if (tx_ready !== 1'b1) ready_bad++;
            @(negedge clk);
            if (i >= 1) begin
                tv[i-1] = txd;
                bv[i-1] = busy;
            end
        end
        tx_valid = 1'b0;
        if (tx_ready !== 1'b1) ready_bad++;
        for (int s = 3; s < 80; s++) begin
            @(negedge clk);
            tv[s] = txd;
            bv[s] = busy;
        end
        exp_tv = expand({24'd0, frame(8'h81), frame(8'h55), frame(8'hFF), frame(8'h00)}, 40, 2);
        exp_bv = ones(80);
        checks++; if (ready_bad !== 0) $display("FAIL t2_ready_held: got %0d low samples expected 0", ready_bad); else passed++;
        checks++; if (tv !== exp_tv) $display("FAIL t2_waveform: got %h expected %h", tv, exp_tv); else passed++;
        checks++; if (bv !== exp_bv) $display("FAIL t2_busy: got %h expected %h", bv, exp_bv); else passed++;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL t2_busy_after: got %b expected 0", busy); else passed++;
        checks++; if (tx_empty !== 1'b1) $display("FAIL t2_empty_after: got %b expected 1", tx_empty); else passed++;
        repeat (2) @(negedge clk);
        rx_en = 1'b0;
        got = '0;
        for (int i = 0; i < rx_q.size() && i < 4; i++) got[i*9 +: 9] = rx_q[i];
        checks++; if (rx_q.size() !== 4) $display("FAIL t2_rx_count: got %0d expected 4", rx_q.size()); else passed++;
        checks++; if (got !== {9'h181, 9'h155, 9'h1FF, 9'h100}) $display("FAIL t2_rx_data: got %h expected %h", got, {9'h181, 9'h155, 9'h1FF, 9'h100}); else passed++;
        $display("test_back_to_back done: %0d/%0d", passed, checks);
    endtask

    task automatic test_overrun;
        logic [7:0] words [6];
        logic [4:0] ready_seen;
        logic [44:0] got;
        int         waited;
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        prescale = 16'd8;
        rx_ps    = 8;
        rx_q.delete();
        rx_en    = 1'b1;
        write_word(words[0]);
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1) $display("FAIL t3_busy_active: got %b expected 1", busy); else passed++;
        for (int i = 1; i < 6; i++) begin
            tx_data  = words[i];
            tx_valid = 1'b1;
            ready_seen[i-1] = tx_ready;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        checks++; if (ready_seen !== 5'b01111) $display("FAIL t3_ready_seq: got %b expected 01111", ready_seen); else passed++;
        checks++; if (overrun_error !== 1'b1) $display("FAIL t3_overrun_set: got %b expected 1", overrun_error); else passed++;
        checks++; if (tx_ready !== 1'b0) $display("FAIL t3_ready_full: got %b expected 0", tx_ready); else passed++;
        waited = 0;
        while (tx_empty !== 1'b1 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (tx_empty !== 1'b1) $display("FAIL t3_drain_timeout: got tx_empty=%b after %0d cycles expected 1", tx_empty, waited); else passed++;
        repeat (2) @(negedge clk);
        rx_en = 1'b0;
        got = '0;
        for (int i = 0; i < rx_q.size() && i < 5; i++) got[i*9 +: 9] = rx_q[i];
        checks++; if (rx_q.size() !== 5) $display("FAIL t3_frame_count: got %0d expected 5", rx_q.size()); else passed++;
        checks++; if (got !== {9'h155, 9'h144, 9'h133, 9'h122, 9'h111}) $display("FAIL t3_rx_data: got %h expected %h", got, {9'h155, 9'h144, 9'h133, 9'h122, 9'h111}); else passed++;
        checks++; if (overrun_error !== 1'b1) $display("FAIL t3_overrun_sticky: got %b expected 1", overrun_error); else passed++;
        $display("test_overrun done: %0d/%0d", passed, checks);
    endtask

    // 0x3C at prescale 0 and 1: line 0,0,0,1,1,1,1,0,0,1 at one cycle per bit.
    task automatic test_min_prescale;
        for (int k = 0; k < 2; k++) begin
            prescale = 16'(k);
            write_word(8'h3C);
            capture(11);
            exp_tv = expand(64'(frame(8'h3C)), 10, 1);
            exp_tv[10] = 1'b1;
            exp_bv = ones(10);
            checks++; if (tv !== exp_tv) $display("FAIL t4_waveform_ps%0d: got %h expected %h", k, tv, exp_tv); else passed++;
            checks++; if (bv !== exp_bv) $display("FAIL t4_busy_ps%0d: got %h expected %h", k, bv, exp_bv); else passed++;
        end
        $display("test_min_prescale done: %0d/%0d", passed, checks);
    endtask

    task automatic test_prescale_change;
        prescale = 16'd16;
        write_word(8'hC3);
        tv = '0;
        for (int s = 0; s < 160; s++) begin
            @(negedge clk);
            tv[s] = txd;
            if (s == 50) prescale = 16'd4;
        end
        exp_tv = expand(64'(frame(8'hC3)), 10, 16);
        checks++; if (tv !== exp_tv) $display("FAIL t5_frame_ps16: got %h expected %h", tv, exp_tv); else passed++;
        write_word(8'h5A);
        capture(41);
        exp_tv = expand(64'(frame(8'h5A)), 10, 4);
        exp_tv[40] = 1'b1;
        exp_bv = ones(40);
        checks++; if (tv !== exp_tv) $display("FAIL t5_next_frame_ps4: got %h expected %h", tv, exp_tv); else passed++;
        checks++; if (bv !== exp_bv) $display("FAIL t5_next_busy: got %h expected %h", bv, exp_bv); else passed++;
        $display("test_prescale_change done: %0d/%0d", passed, checks);
    endtask

    task automatic test_reset_mid_frame;
        int bad;
        prescale = 16'd4;
        write_word(8'hA0);
        write_word(8'hB2);
        write_word(8'hC3);
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1) $display("FAIL t6_busy_before: got %b expected 1", busy); else passed++;
        checks++; if (txd !== 1'b0) $display("FAIL t6_txd_before: got %b expected 0", txd); else passed++;
        checks++; if (overrun_error !== 1'b1) $display("FAIL t6_overrun_before: got %b expected 1", overrun_error); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (txd !== 1'b1) $display("FAIL t6_txd_async: got %b expected 1", txd); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL t6_busy_async: got %b expected 0", busy); else passed++;
        checks++; if (tx_empty !== 1'b1) $display("FAIL t6_empty_async: got %b expected 1", tx_empty); else passed++;
        checks++; if (overrun_error !== 1'b0) $display("FAIL t6_overrun_async: got %b expected 0", overrun_error); else passed++;
        checks++; if (tx_ready !== 1'b1) $display("FAIL t6_ready_async: got %b expected 1", tx_ready); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || tx_empty !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL t6_no_frames_after: got %0d non-idle cycles expected 0", bad); else passed++;
        $display("test_reset_mid_frame done: %0d/%0d", passed, checks);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overrun();
        test_min_prescale();
        test_prescale_change();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
